// File: rtl/download_ddr_packer.sv
// download_ddr_packer: packs 16-bit ROM download words into 64-bit masked DDR line writes
module download_ddr_packer #(
    parameter logic [7:0]  INDEX     = 8'd0,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dl_cs,
    input  logic        dl_wr,
    input  logic [7:0]  dl_index,
    input  logic [26:0] dl_addr,
    input  logic [15:0] dl_dout,
    output logic        dl_wait,
    output logic        ddr_wr,
    output logic [31:0] ddr_addr,
    output logic [63:0] ddr_din,
    output logic [7:0]  ddr_mask,
    output logic [7:0]  ddr_burst_length,
    input  logic        ddr_wait_req,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, FILL, FLUSH} state_t;

    state_t      state_q, state_d;
    logic [63:0] buf_q, buf_d;
    logic [7:0]  mask_q, mask_d;
    logic [23:0] line_q, line_d;
    logic        pend_v_q, pend_v_d;
    logic [15:0] pend_data_q, pend_data_d;
    logic [1:0]  pend_lane_q, pend_lane_d;
    logic [23:0] pend_line_q, pend_line_d;
    logic        eod_q, eod_d;
    logic        cs_q;
    logic        done_q, done_d;

    logic        ours, acc, cs_fall;
    logic [1:0]  lane;
    logic [23:0] line;
    logic [7:0]  merged_mask;

    function automatic logic [63:0] put(input logic [15:0] d, input logic [1:0] l);
        put = 64'(d) << {l, 4'd0};
    endfunction

    function automatic logic [7:0] msk(input logic [1:0] l);
        msk = 8'b11 << {l, 1'b0};
    endfunction

    assign ours        = dl_index == INDEX;
    assign acc         = dl_cs & dl_wr & ours & ~dl_wait;
    assign cs_fall     = cs_q & ~dl_cs;
    assign lane        = dl_addr[2:1];
    assign line        = dl_addr[26:3];
    assign merged_mask = mask_q | msk(lane);

    assign dl_wait          = state_q == FLUSH;
    assign ddr_wr           = state_q == FLUSH;
    assign ddr_addr         = ddr_wr ? BASE_ADDR + {5'd0, line_q, 3'b000} : '0;
    assign ddr_din          = buf_q;
    assign ddr_mask         = mask_q;
    assign ddr_burst_length = 8'd1;
    assign done             = done_q;

    // next-state: fill the line buffer, divert a foreign-line word to pending, flush on full/line change/end
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        mask_d      = mask_q;
        line_d      = line_q;
        pend_v_d    = pend_v_q;
        pend_data_d = pend_data_q;
        pend_lane_d = pend_lane_q;
        pend_line_d = pend_line_q;
        eod_d       = eod_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    buf_d   = put(dl_dout, lane);
                    mask_d  = msk(lane);
                    line_d  = line;
                    state_d = FILL;
                end else if (cs_fall) begin
                    done_d = 1'b1;
                end
            end
            FILL: begin
                if (eod_q) begin
                    state_d = FLUSH;
                end else if (acc && line == line_q) begin
                    buf_d   = (buf_q & ~put(16'hFFFF, lane)) | put(dl_dout, lane);
                    mask_d  = merged_mask;
                    state_d = merged_mask == 8'hFF ? FLUSH : FILL;
                end else if (acc) begin
                    pend_v_d    = 1'b1;
                    pend_data_d = dl_dout;
                    pend_lane_d = lane;
                    pend_line_d = line;
                    state_d     = FLUSH;
                end else if (cs_fall) begin
                    eod_d   = 1'b1;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (cs_fall)
                    eod_d = 1'b1;
                if (!ddr_wait_req) begin
                    if (pend_v_q) begin
                        buf_d    = put(pend_data_q, pend_lane_q);
                        mask_d   = msk(pend_lane_q);
                        line_d   = pend_line_q;
                        pend_v_d = 1'b0;
                        state_d  = FILL;
                    end else begin
                        buf_d   = '0;
                        mask_d  = '0;
                        eod_d   = 1'b0;
                        done_d  = eod_q | cs_fall;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers; cs history only tracks downloads addressed to this index
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            mask_q      <= '0;
            line_q      <= '0;
            pend_v_q    <= 1'b0;
            pend_data_q <= '0;
            pend_lane_q <= '0;
            pend_line_q <= '0;
            eod_q       <= 1'b0;
            cs_q        <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            mask_q      <= mask_d;
            line_q      <= line_d;
            pend_v_q    <= pend_v_d;
            pend_data_q <= pend_data_d;
            pend_lane_q <= pend_lane_d;
            pend_line_q <= pend_line_d;
            eod_q       <= eod_d;
            cs_q        <= dl_cs & ours;
            done_q      <= done_d;
        end
    end
endmodule

// File: tb/tb_download_ddr_packer.sv
// tb_download_ddr_packer: directed table vectors plus hand-written multi-cycle sequences
module tb_download_ddr_packer;
    logic        clock = 1'b0;
    logic        reset;
    logic        dl_cs, dl_wr;
    logic [7:0]  dl_index;
    logic [26:0] dl_addr;
    logic [15:0] dl_dout;
    logic        dl_wait, ddr_wr, ddr_wait_req, done;
    logic [31:0] ddr_addr;
    logic [63:0] ddr_din;
    logic [7:0]  ddr_mask, ddr_burst_length;

    int total = 0;
    int bad = 0;
    int acc_cnt = 0;
    int a0;

    typedef struct {
        logic [26:0] addr;
        logic [15:0] data;
        logic [31:0] exp_addr;
        logic [63:0] exp_din;
        logic [7:0]  exp_mask;
    } vec_t;

    vec_t vecs [5];

    download_ddr_packer dut (
        .clock(clock), .reset(reset), .dl_cs(dl_cs), .dl_wr(dl_wr), .dl_index(dl_index),
        .dl_addr(dl_addr), .dl_dout(dl_dout), .dl_wait(dl_wait), .ddr_wr(ddr_wr),
        .ddr_addr(ddr_addr), .ddr_din(ddr_din), .ddr_mask(ddr_mask),
        .ddr_burst_length(ddr_burst_length), .ddr_wait_req(ddr_wait_req), .done(done)
    );

    always #5 clock = ~clock;

    always @(posedge clock)
        if (ddr_wr && !ddr_wait_req)
            acc_cnt <= acc_cnt + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [26:0] a, input logic [15:0] d, input logic [7:0] idx);
        dl_cs = 1'b1;
        dl_wr = 1'b1;
        dl_addr = a;
        dl_dout = d;
        dl_index = idx;
        step();
        dl_wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{27'h0000002, 16'hA001, 32'h3000_0000, 64'h0000_0000_A001_0000, 8'h0C};
        vecs[1] = '{27'h0000104, 16'hA002, 32'h3000_0100, 64'h0000_A002_0000_0000, 8'h30};
        vecs[2] = '{27'h0000016, 16'hA003, 32'h3000_0010, 64'hA003_0000_0000_0000, 8'hC0};
        vecs[3] = '{27'h7FFFFF8, 16'hA004, 32'h37FF_FFF8, 64'h0000_0000_0000_A004, 8'h03};
        vecs[4] = '{27'h0000040, 16'hFFFF, 32'h3000_0040, 64'h0000_0000_0000_FFFF, 8'h03};
        reset = 1'b1; dl_cs = 0; dl_wr = 0; dl_index = 0; dl_addr = 0; dl_dout = 0; ddr_wait_req = 0;
        step(); step();
        chk("rst_wait", dl_wait, 0);
        chk("rst_wr", ddr_wr, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", ddr_addr, 0);
        chk("rst_din", ddr_din, 0);
        chk("rst_mask", ddr_mask, 0);
        chk("burst_len", ddr_burst_length, 1);
        reset = 1'b0;
        step();

        dl_cs = 1; step();
        wr(27'h0, 16'h1111, 0); wr(27'h2, 16'h2222, 0); wr(27'h4, 16'h3333, 0); wr(27'h6, 16'h4444, 0);
        chk("full_wr", ddr_wr, 1);
        chk("full_addr", ddr_addr, 32'h3000_0000);
        chk("full_din", ddr_din, 64'h4444_3333_2222_1111);
        chk("full_mask", ddr_mask, 8'hFF);
        chk("full_wait", dl_wait, 1);
        chk("full_nodone", done, 0);
        step();
        chk("full_wr_off", ddr_wr, 0);
        chk("full_wait_off", dl_wait, 0);
        dl_cs = 0; step();
        chk("full_done", done, 1);
        step();
        chk("full_done_pulse", done, 0);

        dl_cs = 1; step();
        wr(27'h8, 16'hAAAA, 0); wr(27'hA, 16'hBBBB, 0);
        dl_cs = 0; step();
        chk("part_wr", ddr_wr, 1);
        chk("part_addr", ddr_addr, 32'h3000_0008);
        chk("part_mask", ddr_mask, 8'h0F);
        chk("part_din", ddr_din[31:0], 32'hBBBB_AAAA);
        chk("part_nodone", done, 0);
        step();
        chk("part_done", done, 1);
        step();

        dl_cs = 1; step();
        wr(27'h0, 16'h5555, 0); wr(27'h14, 16'hBEEF, 0);
        chk("pend_wr", ddr_wr, 1);
        chk("pend_addr", ddr_addr, 32'h3000_0000);
        chk("pend_mask", ddr_mask, 8'h03);
        chk("pend_wait", dl_wait, 1);
        step();
        chk("pend_wr_off", ddr_wr, 0);
        chk("pend_wait_off", dl_wait, 0);
        dl_cs = 0; step();
        chk("pend2_wr", ddr_wr, 1);
        chk("pend2_addr", ddr_addr, 32'h3000_0010);
        chk("pend2_mask", ddr_mask, 8'h30);
        chk("pend2_din", ddr_din[47:32], 16'hBEEF);
        step();
        chk("pend2_done", done, 1);
        step();

        ddr_wait_req = 1; dl_cs = 1; step();
        a0 = acc_cnt;
        wr(27'h20, 16'h0001, 0); wr(27'h22, 16'h0002, 0); wr(27'h24, 16'h0003, 0); wr(27'h26, 16'h0004, 0);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) ddr_wait_req = 0;
            chk("hold_wr", ddr_wr, 1);
            chk("hold_addr", ddr_addr, 32'h3000_0020);
            chk("hold_din", ddr_din, 64'h0004_0003_0002_0001);
            chk("hold_mask", ddr_mask, 8'hFF);
            chk("hold_wait", dl_wait, 1);
            dl_wr = (i == 2);
            dl_addr = 27'h0;
            dl_dout = 16'hDEAD;
            step();
        end
        dl_wr = 0;
        chk("hold_wait_off", dl_wait, 0);
        chk("hold_wr_off", ddr_wr, 0);
        chk("hold_acc_count", 64'(acc_cnt - a0), 1);
        dl_cs = 0; step();
        chk("hold_done", done, 1);
        chk("violation_no_flush", ddr_wr, 0);
        step();

        dl_index = 8'd5; dl_cs = 1; step();
        for (int i = 0; i < 4; i++) begin
            wr(27'(2 * i), 16'h9000 + 16'(i), 8'd5);
            chk("foreign_wr", ddr_wr, 0);
            chk("foreign_wait", dl_wait, 0);
        end
        dl_cs = 0; step();
        chk("foreign_done", done, 0);
        step();
        chk("foreign_done2", done, 0);
        chk("foreign_wr2", ddr_wr, 0);
        dl_index = 8'd0;

        foreach (vecs[v]) begin
            dl_cs = 1; step();
            wr(vecs[v].addr, vecs[v].data, 0);
            dl_cs = 0; step();
            chk("vec_wr", ddr_wr, 1);
            chk("vec_addr", ddr_addr, vecs[v].exp_addr);
            chk("vec_din", ddr_din, vecs[v].exp_din);
            chk("vec_mask", ddr_mask, vecs[v].exp_mask);
            step();
            chk("vec_done", done, 1);
            step();
        end

        dl_cs = 1; ddr_wait_req = 1; step();
        wr(27'h40, 16'h1234, 0); wr(27'h42, 16'h1234, 0); wr(27'h44, 16'h1234, 0); wr(27'h46, 16'h1234, 0);
        chk("rstf_wr", ddr_wr, 1);
        reset = 1; step(); reset = 0;
        chk("rstf_wr_off", ddr_wr, 0);
        chk("rstf_wait_off", dl_wait, 0);
        chk("rstf_mask_clr", ddr_mask, 0);
        ddr_wait_req = 0;
        wr(27'h0, 16'h7777, 0);
        dl_cs = 0; step();
        chk("rstf2_wr", ddr_wr, 1);
        chk("rstf2_addr", ddr_addr, 32'h3000_0000);
        chk("rstf2_mask", ddr_mask, 8'h03);
        chk("rstf2_din", ddr_din, 64'h0000_0000_0000_7777);
        step();
        chk("rstf2_done", done, 1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
